// File: rtl/multiplier_8bit.sv
// ============================================================================
// Module      : multiplier_8bit
// Description : Iterative WIDTHxWIDTH -> 2*WIDTH multiplier, one step per
//               clock, with start/busy/done handshake. Radix-2 Booth
//               (two's complement) by default; defining MULT8_UNSIGNED_EN
//               switches to an unsigned shift-add engine with the same timing.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module multiplier_8bit #(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic [2*WIDTH-1:0]   out,
    output logic                 busy,
    output logic                 done
);

    localparam int                 CNT_W    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(WIDTH - 1);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t               state_q;
    logic [CNT_W-1:0]     cnt_q;
    logic [WIDTH-1:0]     m_q;
    logic [WIDTH:0]       acc_q;
    logic [WIDTH-1:0]     q_q;
    logic [2*WIDTH-1:0]   out_q;
    logic                 busy_q;
    logic                 done_q;

    logic [WIDTH:0]       sum_d;
    logic [WIDTH:0]       acc_d;
    logic [WIDTH-1:0]     q_d;

`ifdef MULT8_UNSIGNED_EN
    // Shift-add: the extra accumulator bit catches the carry of each add.
    always_comb begin
        sum_d = acc_q + (q_q[0] ? {1'b0, m_q} : {(WIDTH+1){1'b0}});
        acc_d = {1'b0, sum_d[WIDTH:1]};
        q_d   = {sum_d[0], q_q[WIDTH-1:1]};
    end
`else
    logic                 qm1_q;
    logic                 qm1_d;
    logic [WIDTH:0]       msext;

    // Booth step on {q0, q-1}; the 9-bit accumulator keeps -m representable for m = -2^(WIDTH-1).
    always_comb begin
        msext = {m_q[WIDTH-1], m_q};
        case ({q_q[0], qm1_q})
            2'b01:   sum_d = acc_q + msext;
            2'b10:   sum_d = acc_q - msext;
            default: sum_d = acc_q;
        endcase
        acc_d = {sum_d[WIDTH], sum_d[WIDTH:1]};
        q_d   = {sum_d[0], q_q[WIDTH-1:1]};
        qm1_d = q_q[0];
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            m_q     <= '0;
            acc_q   <= '0;
            q_q     <= '0;
            out_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
`ifndef MULT8_UNSIGNED_EN
            qm1_q   <= 1'b0;
`endif
        end else begin
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        m_q     <= a;
                        q_q     <= b;
                        acc_q   <= '0;
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                        state_q <= ST_RUN;
`ifndef MULT8_UNSIGNED_EN
                        qm1_q   <= 1'b0;
`endif
                    end
                end
                ST_RUN: begin
                    acc_q <= acc_d;
                    q_q   <= q_d;
`ifndef MULT8_UNSIGNED_EN
                    qm1_q <= qm1_d;
`endif
                    // The last step's result goes straight to out so done lands WIDTH edges after acceptance.
                    if (cnt_q == CNT_LAST) begin
                        out_q   <= {acc_d[WIDTH-1:0], q_d};
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                        cnt_q   <= '0;
                        state_q <= ST_IDLE;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign out  = out_q;
    assign busy = busy_q;
    assign done = done_q;

endmodule

`default_nettype wire

// File: tb/tb_multiplier_8bit.sv
// ============================================================================
// Module      : tb_multiplier_8bit
// Description : Directed self-checking bench for multiplier_8bit; expected
//               products follow MULT8_UNSIGNED_EN when it is defined.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_multiplier_8bit;

    localparam int WIDTH = 8;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [7:0]  a     = 8'h00;
    logic [7:0]  b     = 8'h00;
    logic [15:0] out;
    logic        busy;
    logic        done;

    int n_checks = 0;
    int n_fail   = 0;

`ifdef MULT8_UNSIGNED_EN
    localparam int NV = 5;
    localparam logic [7:0]  VA [NV] = '{8'hAC, 8'h7F, 8'hFF, 8'h80, 8'h00};
    localparam logic [7:0]  VB [NV] = '{8'h34, 8'hC0, 8'hFF, 8'h80, 8'h9C};
    localparam logic [15:0] VP [NV] = '{16'h22F0, 16'h5F40, 16'hFE01, 16'h4000, 16'h0000};
    localparam logic [15:0] HS_P2   = 16'h22F0;
`else
    localparam int NV = 10;
    localparam logic [7:0]  VA [NV] = '{8'h65, 8'hAC, 8'hB1, 8'h7F, 8'hBB,
                                        8'hD3, 8'h80, 8'h80, 8'hFF, 8'h00};
    localparam logic [7:0]  VB [NV] = '{8'h56, 8'h34, 8'h54, 8'hC0, 8'h55,
                                        8'h56, 8'h80, 8'h7F, 8'hFF, 8'h9C};
    localparam logic [15:0] VP [NV] = '{16'h21EE, 16'hEEF0, 16'hE614, 16'hE040, 16'hE917,
                                        16'hF0E2, 16'h4000, 16'hC080, 16'h0001, 16'h0000};
    localparam logic [15:0] HS_P2   = 16'hEEF0;
`endif

    always #5 clk = ~clk;

    multiplier_8bit #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .a     (a),
        .b     (b),
        .out   (out),
        .busy  (busy),
        .done  (done)
    );

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%04h, expected 0x%04h", tag, got, exp);
        end
    endtask

    // Entered and left at posedge+1 with the DUT idle.
    task automatic run_op(input string tag, input logic [7:0] ta, input logic [7:0] tb_v,
                          input logic [15:0] exp);
        logic        early;
        logic [15:0] prev;
        prev  = out;
        a     = ta;
        b     = tb_v;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        a     = ~ta;
        b     = tb_v + 8'd37;
        check({tag, " busy_after_accept"}, 16'(busy), 16'd1);
        early = 1'b0;
        for (int k = 1; k < 8; k++) begin
            @(posedge clk); #1;
            if (done || out !== prev || !busy) early = 1'b1;
        end
        check({tag, " early_change"}, 16'(early), 16'd0);
        @(posedge clk); #1;
        check({tag, " out"}, out, exp);
        check({tag, " done_pulse"}, 16'(done), 16'd1);
        check({tag, " busy_low"}, 16'(busy), 16'd0);
        @(posedge clk); #1;
        check({tag, " done_clear"}, 16'(done), 16'd0);
        check({tag, " out_hold"}, out, exp);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic seen;

        repeat (2) @(posedge clk);
        #1;
        check("reset out", out, 16'h0000);
        check("reset busy", 16'(busy), 16'd0);
        check("reset done", 16'(done), 16'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < NV; i++) begin
            run_op($sformatf("vec%0d", i), VA[i], VB[i], VP[i]);
        end

        // Handshake: start held high, operands changed while busy.
        a     = 8'h65;
        b     = 8'h56;
        start = 1'b1;
        @(posedge clk); #1;
        check("hs busy1", 16'(busy), 16'd1);
        a = 8'hAC;
        b = 8'h34;
        for (int k = 1; k < 8; k++) begin
            @(posedge clk); #1;
            if (k == 4) check("hs out_hold_mid", out, VP[NV-1]);
        end
        @(posedge clk); #1;
        check("hs out1", out, 16'h21EE);
        check("hs done1", 16'(done), 16'd1);
        check("hs busy_in_done", 16'(busy), 16'd0);
        @(posedge clk); #1;
        check("hs busy2_accepted", 16'(busy), 16'd1);
        check("hs done1_clear", 16'(done), 16'd0);
        check("hs out1_hold", out, 16'h21EE);
        a = 8'hFF;
        b = 8'hFF;
        for (int k = 1; k < 8; k++) begin
            @(posedge clk); #1;
        end
        check("hs out1_hold_late", out, 16'h21EE);
        @(posedge clk); #1;
        check("hs out2", out, HS_P2);
        check("hs done2", 16'(done), 16'd1);
        start = 1'b0;
        @(posedge clk); #1;
        check("hs idle_after", 16'(busy), 16'd0);

        // Asynchronous reset mid-operation.
        a     = 8'h7F;
        b     = 8'hC0;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst out", out, 16'h0000);
        check("arst busy", 16'(busy), 16'd0);
        check("arst done", 16'(done), 16'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        seen = 1'b0;
        for (int k = 0; k < 12; k++) begin
            @(posedge clk); #1;
            if (done || busy) seen = 1'b1;
        end
        check("arst no_done_after", 16'(seen), 16'd0);
        check("arst out_stays", out, 16'h0000);

        run_op("post_reset", 8'h65, 8'h56, 16'h21EE);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
